// File: rtl/seg_dynamic_scan.sv
// seg_dynamic_scan
// Six-digit multiplexed 7-segment driver. A free-running shift-add-3 converter
// turns the saturated 20-bit input into six BCD digits. A dwell counter then
// steps through the digits, and each digit's pattern is formed with leading-zero
// blanking, a minus sign and decimal points applied.
//
// Converter FSM states:
//   state | meaning
//   IDLE  | latch min(data,DATA_MAX), clear BCD working register
//   SHIFT | 20 shift-add-3 steps, one input bit per cycle
//   DONE  | publish the six BCD nibbles to the display registers
module seg_dynamic_scan #(
  parameter logic [15:0] CNT_MAX  = 16'd49_999,
  parameter logic [19:0] DATA_MAX = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  conv_state_t state;
  logic [19:0] shift_reg;
  logic [23:0] bcd_work;
  logic [4:0]  bit_cnt;
  logic [23:0] bcd_disp;

  logic [15:0] cnt_scan;
  logic [2:0]  idx;

  logic [23:0] bcd_adj;
  logic [3:0]  cur_digit;
  logic [2:0]  msd;
  logic [2:0]  pt_hi;
  logic [2:0]  keep;
  logic [7:0]  pattern;

  // Segment code for one decimal numeral (active-low, dp off)
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Add-3 correction on every working nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < 6; i++) begin
      if (bcd_work[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_work[i*4 +: 4] + 4'd3;
    end
  end

  // Converter FSM: continuous 22-cycle IDLE/SHIFT x20/DONE loop
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      shift_reg <= 20'd0;
      bcd_work  <= 24'd0;
      bit_cnt   <= 5'd0;
      bcd_disp  <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          shift_reg <= (data > DATA_MAX) ? DATA_MAX : data;
          bcd_work  <= 24'd0;
          bit_cnt   <= 5'd19;
          state     <= SHIFT;
        end
        SHIFT: begin
          bcd_work  <= {bcd_adj[22:0], shift_reg[19]};
          shift_reg <= {shift_reg[18:0], 1'b0};
          if (bit_cnt == 5'd0) begin
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        DONE: begin
          bcd_disp <= bcd_work;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit dwell counter and scan index
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_scan <= 16'd0;
      idx      <= 3'd0;
    end else if (cnt_scan == CNT_MAX) begin
      cnt_scan <= 16'd0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt_scan <= cnt_scan + 16'd1;
    end
  end

  // Blanking extent: highest of the most significant nonzero digit and highest lit DP
  always_comb begin
    msd   = 3'd0;
    pt_hi = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bcd_disp[i*4 +: 4] != 4'd0) msd = 3'(i);
      if (point[i]) pt_hi = 3'(i);
    end
    keep = (msd > pt_hi) ? msd : pt_hi;
  end

  // Pattern for the digit currently addressed by idx
  always_comb begin
    case (idx)
      3'd0:    cur_digit = bcd_disp[3:0];
      3'd1:    cur_digit = bcd_disp[7:4];
      3'd2:    cur_digit = bcd_disp[11:8];
      3'd3:    cur_digit = bcd_disp[15:12];
      3'd4:    cur_digit = bcd_disp[19:16];
      3'd5:    cur_digit = bcd_disp[23:20];
      default: cur_digit = 4'd0;
    endcase
    if (idx <= keep)
      pattern = seg_code(cur_digit);
    else if (sign && (keep < 3'd5) && (idx == keep + 3'd1))
      pattern = 8'hBF;
    else
      pattern = 8'hFF;
    if (idx <= 3'd5 && point[idx])
      pattern[7] = 1'b0;
  end

  // Registered digit select and segment outputs, blanked when disabled
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'd1 << idx;
      seg <= pattern;
    end else begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// tb_seg_dynamic_scan
// Randomized and directed checks of seg_dynamic_scan against a decimal-arithmetic
// reference model of the displayed digit patterns and scan rotation.
module tb_seg_dynamic_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [19:0] data    = 20'd0;
  logic [5:0]  point   = 6'd0;
  logic        sign    = 1'b0;
  logic        seg_en  = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  seg_dynamic_scan #(.CNT_MAX(16'd4), .DATA_MAX(20'd999_999)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .data   (data),
    .point  (point),
    .sign   (sign),
    .seg_en (seg_en),
    .sel    (sel),
    .seg    (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] numeral(input int d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  // Reference: expected pattern of digit position d for the given inputs
  function automatic logic [7:0] exp_seg(input int d, input logic [19:0] dat,
                                         input logic [5:0] pt, input logic sg);
    int v, pw, keep, msd, ph;
    int dig [6];
    logic [7:0] p;
    v  = (int'(dat) > 999999) ? 999999 : int'(dat);
    pw = 1;
    for (int i = 0; i < 6; i++) begin
      dig[i] = (v / pw) % 10;
      pw = pw * 10;
    end
    msd = 0;
    ph  = 0;
    for (int i = 0; i < 6; i++) begin
      if (dig[i] != 0) msd = i;
      if (pt[i]) ph = i;
    end
    keep = (msd > ph) ? msd : ph;
    if (d <= keep)                            p = numeral(dig[d]);
    else if (sg && keep < 5 && d == keep + 1) p = 8'hBF;
    else                                      p = 8'hFF;
    if (pt[d]) p[7] = 1'b0;
    return p;
  endfunction

  function automatic int pos_of(input logic [5:0] s);
    int r = -1;
    for (int i = 0; i < 6; i++) if (s[i]) r = i;
    return r;
  endfunction

  // Watch 36 cycles: every sample's pattern, all digits visited, 5-cycle rotation
  task automatic observe(input string tag);
    logic [5:0] s [36];
    logic [5:0] seen;
    int f, p0;
    seen = 6'd0;
    for (int c = 0; c < 36; c++) begin
      @(negedge sys_clk);
      s[c] = sel;
      check({tag, "_onehot"}, 32'($onehot(sel)), 32'd1);
      if ($onehot(sel)) begin
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg(pos_of(sel), data, point, sign)));
        seen = seen | sel;
      end
    end
    check({tag, "_all_digits"}, 32'(seen), 32'h3F);
    f = -1;
    for (int k = 35; k > 0; k--) if (s[k] != s[0]) f = k;
    check({tag, "_first_step"}, 32'((f >= 1) && (f <= 5)), 32'd1);
    if (f >= 1) begin
      p0 = pos_of(s[f]);
      check({tag, "_step_dir"}, 32'(pos_of(s[f])), 32'((pos_of(s[0]) + 1) % 6));
      for (int k = f; k < 36; k++)
        check({tag, "_rotation"}, 32'(s[k]), 32'(6'd1 << ((p0 + (k - f) / 5) % 6)));
    end
  endtask

  task automatic apply(input logic [19:0] d, input logic [5:0] p, input logic sg, input string tag);
    data  = d;
    point = p;
    sign  = sg;
    repeat (50) @(negedge sys_clk);
    observe(tag);
  endtask

  initial begin
    #1 sys_rst = 1'b1;
    #1;
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_seg", 32'(seg), 32'hFF);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    apply(20'd0,       6'b000000, 1'b0, "zero");
    apply(20'd123456,  6'b000000, 1'b0, "full");
    apply(20'd42,      6'b000000, 1'b1, "neg42");
    apply(20'd5,       6'b000100, 1'b0, "point2");
    apply(20'hFFFFF,   6'b000000, 1'b1, "saturate");
    apply(20'd0,       6'b000000, 1'b1, "neg0");
    apply(20'd999999,  6'b100001, 1'b1, "max_pt");

    // Direct spot checks of the saturated case
    check("sat_digit5", 32'(exp_seg(5, 20'hFFFFF, 6'd0, 1'b1)), 32'h90);

    // Display disable mid-dwell, then resume
    data = 20'd3071; point = 6'd0; sign = 1'b0;
    repeat (50) @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    seg_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      check("dis_sel", 32'(sel), 32'd0);
      check("dis_seg", 32'(seg), 32'hFF);
    end
    seg_en = 1'b1;
    observe("reenable");

    // Reset at an arbitrary point of the conversion cycle
    for (int r = 0; r < 3; r++) begin
      data  = 20'($urandom_range(1, 999999));
      point = 6'd0;
      sign  = 1'($urandom_range(0, 1));
      repeat (50) @(negedge sys_clk);
      repeat ($urandom_range(0, 21)) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      check("rst_mid_sel", 32'(sel), 32'd0);
      check("rst_mid_seg", 32'(seg), 32'hFF);
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (44) @(negedge sys_clk);
      observe("post_reset");
    end

    // Randomized values, decimal points and sign
    for (int n = 0; n < 10; n++) begin
      logic [19:0] d;
      logic [5:0]  p;
      case ($urandom_range(0, 3))
        0: d = 20'($urandom_range(0, 9));
        1: d = 20'($urandom_range(0, 9999));
        2: d = 20'($urandom_range(0, 999999));
        default: d = 20'($urandom_range(0, 1048575));
      endcase
      p = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      apply(d, p, 1'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
